hex_display: RTL



---
 rtl/hex_display.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/hex_display.sv
// hex_display: 4-digit common-anode 7-segment driver for the core's debug word.
// The word is snapshotted once per scan frame so that a frame never tears. A
// debounced push-button toggles which 16-bit half of the word is shown.
// Optional feature macro: HEX_DISPLAY_BLANK_EN (leading-zero blanking).
module hex_display #(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        btn_page,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        page
);

  localparam int SCAN_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Nibble d of a 16-bit half.
  function automatic logic [3:0] pick_nib(input logic [15:0] half, input logic [1:0] d);
    logic [3:0] n;
    case (d)
      2'd0:    n = half[3:0];
      2'd1:    n = half[7:4];
      2'd2:    n = half[11:8];
      default: n = half[15:12];
    endcase
    return n;
  endfunction

  // True when digit d is a leading zero (it and every higher nibble are zero).
  // Digit 0 always stays lit so a zero value still shows "0".
  function automatic logic lead_zero(input logic [15:0] half, input logic [1:0] d);
    logic z;
    case (d)
      2'd0:    z = 1'b0;
      2'd1:    z = (half[15:4] == 12'h000);
      2'd2:    z = (half[15:8] == 8'h00);
      default: z = (half[15:12] == 4'h0);
    endcase
    return z;
  endfunction

  logic [SCAN_W-1:0] scan_cnt;
  logic              tc;
  logic [1:0]        digit;
  logic [31:0]       snap;

  logic              sync_p0;
  logic              sync_p1;
  logic              btn_acc;
  logic              btn_acc_d;
  logic [DEB_W-1:0]  deb_cnt;

  logic [15:0]       half;
  logic [3:0]        nib;
  logic [6:0]        seg_nxt;
  logic [3:0]        an_nxt;
  logic              dp_nxt;

  assign tc = (scan_cnt == SCAN_LAST);

  // Prescaler and digit counter; the digit advances on each terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else begin
      if (tc) begin
        scan_cnt <= '0;
        digit    <= digit + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end
  end

  // Snapshot loads on the edge where digit wraps 3->0, so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap <= 32'h0;
    end else if (tc && (digit == 2'd3)) begin
      snap <= value;
    end
  end

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_page;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: accept the new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_acc <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_p1 == btn_acc) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_acc <= sync_p1;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Page toggles one cycle after the accepted level rises; release is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_acc_d <= 1'b0;
      page      <= 1'b0;
    end else begin
      btn_acc_d <= btn_acc;
      if (btn_acc && !btn_acc_d) begin
        page <= ~page;
      end
    end
  end

  // Next display pattern from the current digit, page and snapshot.
  always_comb begin
    half    = page ? snap[31:16] : snap[15:0];
    nib     = pick_nib(half, digit);
    seg_nxt = hex7(nib);
`ifdef HEX_DISPLAY_BLANK_EN
    if (lead_zero(half, digit)) begin
      seg_nxt = 7'b1111111;
    end
`endif
    an_nxt  = ~(4'b0001 << digit);
    dp_nxt  = ~((digit == 2'd3) && page);
  end

  // Registered display outputs; blank and all anodes off while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= 7'b1111111;
      an  <= 4'b1111;
      dp  <= 1'b1;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
      dp  <= dp_nxt;
    end
  end

`ifndef HEX_DISPLAY_BLANK_EN
  // lead_zero is only needed by the blanking build.
  logic unused_blank;
  assign unused_blank = lead_zero(16'h0, 2'd0);
`endif

endmodule
